// File: rtl/control_loader_pkg.sv
// Shared types and helpers for the boot-time control store loader.
package control_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CHK    = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } loader_state_t;

    function automatic int bytes_per_word(input int dw);
        return (dw + 7) / 8;
    endfunction

endpackage

// File: rtl/control_store_loader.sv
// Parses a framed byte stream (length, little-endian payload words, checksum)
// and writes the payload into the control store from address 0 upward.
//
// state  | meaning
// IDLE   | waiting for i_start after reset
// LEN_LO | expecting low byte of word count
// LEN_HI | expecting high byte of word count, range-checked on arrival
// DATA   | assembling payload bytes into words and writing them
// CHK    | expecting checksum byte
// DONE   | last load finished with a good checksum
// ERROR  | last load failed on length or checksum
module control_store_loader
    import control_loader_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 20
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_rx_valid,
    input  logic [7:0]    i_rx_data,
    output logic          o_rx_ready,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_wren,
    output logic [DW-1:0] o_mem_data,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_error,
    output logic [AW:0]   o_count
);

    localparam int BPW = bytes_per_word(DW);
    localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int BW  = (BPW > 1) ? 8 * (BPW - 1) : 8;
    localparam int CW  = AW + 1;
    localparam logic [16:0] MAXW = 17'(1) << AW;

    if (AW < 1 || AW > 16) begin : g_bad_aw
        $error("control_store_loader: AW=%0d outside 1..16", AW);
    end
    if (DW < 1 || DW > 64) begin : g_bad_dw
        $error("control_store_loader: DW=%0d outside 1..64", DW);
    end

    loader_state_t state_q, state_d;

    logic [7:0]    len_lo_q;
    logic [CW-1:0] n_q;
    logic [CW-1:0] words_q;
    logic [IW-1:0] idx_q;
    logic [7:0]    sum_q;
    logic [BW-1:0] buf_q;
    logic [AW-1:0] addr_q;
    logic [CW-1:0] count_q;
    logic [DW-1:0] data_q;
    logic          wren_q;
    logic          done_q;
    logic          error_q;

    logic          busy;
    logic          fire;
    logic          start_ok;
    logic [7:0]    sum_next;
    logic [16:0]   len_full;
    logic          len_bad;
    logic          idx_last;
    logic          last_word;
    logic [DW-1:0] word_asm;

    assign busy      = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                       (state_q == DATA)   || (state_q == CHK);
    assign fire      = i_rx_valid && busy;
    assign start_ok  = i_start && !busy;
    assign sum_next  = sum_q + i_rx_data;
    assign len_full  = {1'b0, i_rx_data, len_lo_q};
    assign len_bad   = (len_full == 17'd0) || (len_full > MAXW);
    assign idx_last  = (idx_q == IW'(BPW - 1));
    assign last_word = ((words_q + CW'(1)) == n_q);

    // The final byte of a word is taken straight from the input so the write
    // can be registered on the edge that accepts it; bits above DW fall away.
    for (genvar b = 0; b < DW; b++) begin : g_word
        if (b / 8 == BPW - 1) begin : g_in
            assign word_asm[b] = i_rx_data[b % 8];
        end else begin : g_buf
            assign word_asm[b] = buf_q[b];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE, ERROR: if (i_start) state_d = LEN_LO;
            LEN_LO:            if (fire) state_d = LEN_HI;
            LEN_HI:            if (fire) state_d = len_bad ? ERROR : DATA;
            DATA:              if (fire && idx_last && last_word) state_d = CHK;
            CHK:               if (fire) state_d = (sum_next == 8'd0) ? DONE : ERROR;
            default:           state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            len_lo_q <= '0;
            n_q      <= '0;
            words_q  <= '0;
            idx_q    <= '0;
            sum_q    <= '0;
            buf_q    <= '0;
            addr_q   <= '0;
            count_q  <= '0;
            data_q   <= '0;
            wren_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            wren_q <= 1'b0;
            // Address and count advance the cycle after each write pulse.
            if (wren_q) begin
                addr_q  <= addr_q + AW'(1);
                count_q <= count_q + CW'(1);
            end
            if (start_ok) begin
                done_q  <= 1'b0;
                error_q <= 1'b0;
                count_q <= '0;
                addr_q  <= '0;
                idx_q   <= '0;
                sum_q   <= '0;
                words_q <= '0;
            end
            if (fire) sum_q <= sum_next;
            unique case (state_q)
                LEN_LO: if (fire) len_lo_q <= i_rx_data;
                LEN_HI: if (fire) begin
                    n_q <= CW'(len_full);
                    if (len_bad) error_q <= 1'b1;
                end
                DATA: if (fire) begin
                    if (idx_last) begin
                        data_q  <= word_asm;
                        wren_q  <= 1'b1;
                        idx_q   <= '0;
                        words_q <= words_q + CW'(1);
                    end else begin
                        for (int i = 0; i < BPW - 1; i++) begin
                            if (idx_q == IW'(i)) buf_q[i*8 +: 8] <= i_rx_data;
                        end
                        idx_q <= idx_q + IW'(1);
                    end
                end
                CHK: if (fire) begin
                    if (sum_next == 8'd0) done_q  <= 1'b1;
                    else                  error_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_rx_ready = busy;
    assign o_busy     = busy;
    assign o_mem_addr = addr_q;
    assign o_mem_wren = wren_q;
    assign o_mem_data = data_q;
    assign o_done     = done_q;
    assign o_error    = error_q;
    assign o_count    = count_q;

endmodule

// File: tb/tb_control_store_loader.sv
// Directed bench for control_store_loader at AW=4, DW=20 (3 bytes per word, 16 words max).
module tb_control_store_loader;

    localparam int AW = 4;
    localparam int DW = 20;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_start = 1'b0;
    logic          i_rx_valid = 1'b0;
    logic [7:0]    i_rx_data = 8'h00;
    logic          o_rx_ready;
    logic [AW-1:0] o_mem_addr;
    logic          o_mem_wren;
    logic [DW-1:0] o_mem_data;
    logic          o_busy;
    logic          o_done;
    logic          o_error;
    logic [AW:0]   o_count;

    control_store_loader #(.AW(AW), .DW(DW)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_rx_valid (i_rx_valid),
        .i_rx_data  (i_rx_data),
        .o_rx_ready (o_rx_ready),
        .o_mem_addr (o_mem_addr),
        .o_mem_wren (o_mem_wren),
        .o_mem_data (o_mem_data),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_error    (o_error),
        .o_count    (o_count)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    // Write log captured on the rising edge (values held over the prior cycle).
    int            wr_total = 0;
    logic [AW-1:0] wr_addr [256];
    logic [DW-1:0] wr_data [256];

    always @(posedge i_clk) begin
        if (o_mem_wren && wr_total < 256) begin
            wr_addr[wr_total] = o_mem_addr;
            wr_data[wr_total] = o_mem_data;
            wr_total = wr_total + 1;
        end
    end

    logic [7:0] frame [64];
    int         frame_len;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge i_clk);
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    // Presents one byte from a negedge and returns at the negedge after it transfers.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        while (!o_rx_ready && t < 50) begin
            @(negedge i_clk);
            t++;
        end
        if (t >= 50) check("ready_timeout", 64'(o_rx_ready), 64'd1);
        @(negedge i_clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic send_frame(input bit gaps, input bit start_mid);
        for (int i = 0; i < frame_len; i++) begin
            if (gaps) idle(int'($urandom_range(0, 3)));
            if (start_mid && (i == 3 || i == 6)) pulse_start();
            send_byte(frame[i]);
        end
    endtask

    task automatic set_nominal(input logic [7:0] b4, input logic [7:0] chk);
        frame[0] = 8'h02; frame[1] = 8'h00;
        frame[2] = 8'h11; frame[3] = 8'h22; frame[4] = b4;
        frame[5] = 8'h44; frame[6] = 8'h55; frame[7] = 8'h06;
        frame[8] = chk;
        frame_len = 9;
    endtask

    int base;

    initial begin
        // Reset state
        idle(2);
        check("rst_ready", 64'(o_rx_ready), 64'd0);
        check("rst_busy",  64'(o_busy),     64'd0);
        check("rst_wren",  64'(o_mem_wren), 64'd0);
        check("rst_flags", 64'({o_done, o_error}), 64'd0);
        check("rst_addr",  64'(o_mem_addr), 64'd0);
        check("rst_data",  64'(o_mem_data), 64'd0);
        check("rst_count", 64'(o_count),    64'd0);
        i_rst = 1'b0;
        idle(2);
        check("idle_ready", 64'(o_rx_ready), 64'd0);

        // Nominal load
        base = wr_total;
        pulse_start();
        check("nom_busy", 64'(o_busy), 64'd1);
        set_nominal(8'h03, 8'h29);
        send_frame(1'b0, 1'b0);
        check("nom_done_lat", 64'(o_done), 64'd1);
        idle(3);
        check("nom_nwr",   64'(wr_total - base), 64'd2);
        check("nom_a0",    64'(wr_addr[base]),     64'd0);
        check("nom_d0",    64'(wr_data[base]),     64'h32211);
        check("nom_a1",    64'(wr_addr[base+1]),   64'd1);
        check("nom_d1",    64'(wr_data[base+1]),   64'h65544);
        check("nom_error", 64'(o_error), 64'd0);
        check("nom_count", 64'(o_count), 64'd2);
        check("nom_busy_end", 64'(o_busy), 64'd0);

        // Upper bits of last byte masked
        base = wr_total;
        pulse_start();
        check("mask_done_clr", 64'(o_done), 64'd0);
        set_nominal(8'hF3, 8'h39);
        send_frame(1'b0, 1'b0);
        idle(3);
        check("mask_d0",   64'(wr_data[base]), 64'h32211);
        check("mask_done", 64'(o_done), 64'd1);

        // Bad length: zero
        base = wr_total;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        check("len0_err",   64'(o_error), 64'd1);
        check("len0_ready", 64'(o_rx_ready), 64'd0);
        idle(2);
        check("len0_nwr",   64'(wr_total - base), 64'd0);
        check("len0_count", 64'(o_count), 64'd0);

        // Bad length: 17 words
        pulse_start();
        check("len17_errclr", 64'(o_error), 64'd0);
        send_byte(8'h11);
        send_byte(8'h00);
        check("len17_err",   64'(o_error), 64'd1);
        idle(2);
        check("len17_nwr",   64'(wr_total - base), 64'd0);
        check("len17_count", 64'(o_count), 64'd0);
        check("len17_done",  64'(o_done), 64'd0);

        // Bad checksum: writes still land
        base = wr_total;
        pulse_start();
        set_nominal(8'h03, 8'h28);
        send_frame(1'b0, 1'b0);
        check("chk_err_lat", 64'(o_error), 64'd1);
        idle(3);
        check("chk_nwr",   64'(wr_total - base), 64'd2);
        check("chk_d1",    64'(wr_data[base+1]), 64'h65544);
        check("chk_done",  64'(o_done), 64'd0);
        check("chk_count", 64'(o_count), 64'd2);

        // Gaps in valid plus ignored start pulses mid-load
        base = wr_total;
        pulse_start();
        set_nominal(8'h03, 8'h29);
        send_frame(1'b1, 1'b1);
        idle(3);
        check("gap_nwr",   64'(wr_total - base), 64'd2);
        check("gap_a0",    64'(wr_addr[base]),   64'd0);
        check("gap_d0",    64'(wr_data[base]),   64'h32211);
        check("gap_a1",    64'(wr_addr[base+1]), 64'd1);
        check("gap_d1",    64'(wr_data[base+1]), 64'h65544);
        check("gap_flags", 64'({o_done, o_error}), 64'b10);
        check("gap_count", 64'(o_count), 64'd2);

        // Maximum length: 16 words of 01 01 01, checksum 0xC0
        base = wr_total;
        frame[0] = 8'h10; frame[1] = 8'h00;
        for (int i = 0; i < 48; i++) frame[2+i] = 8'h01;
        frame[50] = 8'hC0;
        frame_len = 51;
        pulse_start();
        send_frame(1'b0, 1'b0);
        idle(3);
        check("max_nwr",   64'(wr_total - base), 64'd16);
        check("max_a15",   64'(wr_addr[base+15]), 64'd15);
        check("max_d15",   64'(wr_data[base+15]), 64'h10101);
        check("max_a7",    64'(wr_addr[base+7]),  64'd7);
        check("max_count", 64'(o_count), 64'd16);
        check("max_wrap",  64'(o_mem_addr), 64'd0);
        check("max_done",  64'(o_done), 64'd1);

        // Reset mid-DATA after four payload bytes
        pulse_start();
        set_nominal(8'h03, 8'h29);
        frame_len = 6;
        send_frame(1'b0, 1'b0);
        check("mid_busy", 64'(o_busy), 64'd1);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("mid_rst_outs", 64'({o_rx_ready, o_mem_wren, o_busy, o_done, o_error}), 64'd0);
        check("mid_rst_addr",  64'(o_mem_addr), 64'd0);
        check("mid_rst_data",  64'(o_mem_data), 64'd0);
        check("mid_rst_count", 64'(o_count),    64'd0);
        i_rst = 1'b0;
        idle(1);
        base = wr_total;
        pulse_start();
        set_nominal(8'h03, 8'h29);
        send_frame(1'b0, 1'b0);
        idle(3);
        check("mid_nwr",   64'(wr_total - base), 64'd2);
        check("mid_d1",    64'(wr_data[base+1]), 64'h65544);
        check("mid_flags", 64'({o_done, o_error}), 64'b10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
